// File: rtl/hamming_sec_scrubber.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hamming_sec_scrubber : background SEC scrubber sharing a single memory port
// Revision 1.0
// ---------------------------------------------------------------------------
module hamming_sec_scrubber #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              user_req,
    input  logic              user_wr_en,
    input  logic [ADDR_W-1:0] user_addr,
    input  logic [11:0]       user_wdata,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata,
    output logic              busy,
    output logic              pass_done,
    output logic              err_corrected,
    output logic              err_uncorrectable,
    output logic [ADDR_W-1:0] err_addr,
    output logic [7:0]        corr_count
);
    localparam int                CNT_W     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((INTERVAL > 0) ? INTERVAL - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] scan_addr_q;
    logic [11:0]       fix_q;
    logic              conflict_q;
    logic              pass_done_q, err_corr_q, err_unc_q;
    logic [ADDR_W-1:0] err_addr_q;
    logic [7:0]        corr_count_q;

    logic [3:0]        syn;
    logic              auto_fire, user_hit, scrub_wr;

    function automatic logic [3:0] syndrome(input logic [11:0] cw);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 1; i <= 12; i++) begin
            if (cw[i-1]) s = s ^ 4'(i);
        end
        return s;
    endfunction

    assign syn       = syndrome(mem_rdata);
    assign auto_fire = (INTERVAL != 0) && (cnt_q == CNT_LAST);
    assign user_hit  = user_req && user_wr_en && (user_addr == scan_addr_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start || auto_fire) state_d = S_READ;
            S_READ:  if (!user_req) state_d = S_CHECK;
            S_CHECK: begin
                if (syn != 4'd0 && syn <= 4'd12) state_d = S_WRITE;
                else                             state_d = S_NEXT;
            end
            S_WRITE: if (!user_req) state_d = S_NEXT;
            S_NEXT:  state_d = (scan_addr_q == ADDR_LAST) ? S_IDLE : S_READ;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        scrub_wr = (state_q == S_WRITE) && !user_req && !conflict_q;
    end

    // The user path always owns the port when it asks for it.
    assign mem_wr_en = user_req ? user_wr_en : scrub_wr;
    assign mem_addr  = user_req ? user_addr  : scan_addr_q;
    assign mem_wdata = user_req ? user_wdata : fix_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            scan_addr_q  <= '0;
            fix_q        <= '0;
            conflict_q   <= 1'b0;
            pass_done_q  <= 1'b0;
            err_corr_q   <= 1'b0;
            err_unc_q    <= 1'b0;
            err_addr_q   <= '0;
            corr_count_q <= '0;
        end else begin
            pass_done_q <= 1'b0;
            err_corr_q  <= 1'b0;
            err_unc_q   <= 1'b0;
            if (state_q == S_IDLE && state_d == S_IDLE && INTERVAL != 0)
                cnt_q <= cnt_q + CNT_W'(1);
            else
                cnt_q <= '0;
            case (state_q)
                S_READ: conflict_q <= 1'b0;
                S_CHECK: begin
                    if (user_hit) conflict_q <= 1'b1;
                    fix_q <= mem_rdata ^ (12'd1 << (syn - 4'd1));
                    if (syn >= 4'd13) begin
                        err_unc_q  <= 1'b1;
                        err_addr_q <= scan_addr_q;
                    end
                end
                S_WRITE: begin
                    if (user_hit) conflict_q <= 1'b1;
                    if (scrub_wr) begin
                        err_corr_q <= 1'b1;
                        err_addr_q <= scan_addr_q;
                        if (corr_count_q != 8'hFF) corr_count_q <= corr_count_q + 8'd1;
                    end
                end
                S_NEXT: begin
                    if (scan_addr_q == ADDR_LAST) begin
                        pass_done_q <= 1'b1;
                        scan_addr_q <= '0;
                    end else begin
                        scan_addr_q <= scan_addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pass_done         = pass_done_q;
    assign err_corrected     = err_corr_q;
    assign err_uncorrectable = err_unc_q;
    assign err_addr          = err_addr_q;
    assign corr_count        = corr_count_q;
endmodule
`default_nettype wire
